// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device. The host holds the clock low to
// inhibit the device, then requests to send. The device then clocks out the
// data bits, odd parity and the stop bit, and acknowledges the frame.
// Both lines are open-drain. A 1 on an *_oe output pulls that line low.
// Optional build macro: PS2_TX_ACK_CHECK_EN. When it is defined, a missing
// device acknowledge on the 11th falling edge reports err. When it is
// undefined, any 11th edge is accepted and err reports only timeouts.
// INHIBIT_CYCLES must be at least 2.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic             clk_sync_p0;
  logic             clk_sync_p1;
  logic             clk_sync_p2;
  logic             dat_sync_p0;
  logic             dat_sync_p1;
  logic             fall;
  logic             timed_out;
  logic             line_idle;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       data_r;
  logic             parity_r;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Device clock falling edge, as seen through the synchronizer.
  assign fall      = clk_sync_p2 & ~clk_sync_p1;
  // The silence limit is reached on this cycle unless an edge arrives now.
  assign timed_out = ~fall & (to_cnt == TO_LAST);
  assign line_idle = clk_sync_p1 & dat_sync_p1;

  // Two-flop synchronizers, plus a delayed copy of the clock for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      clk_sync_p2 <= 1'b1;
      dat_sync_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
    end else begin
      // stage p0 -> p1: metastability settling
      clk_sync_p0 <= ps2_clk_in;
      dat_sync_p0 <= ps2_dat_in;
      clk_sync_p1 <= clk_sync_p0;
      dat_sync_p1 <= dat_sync_p0;
      // stage p1 -> p2: previous synced clock for the falling-edge compare
      clk_sync_p2 <= clk_sync_p1;
    end
  end

  // Transfer sequencer. It also owns the line drivers, the status pulses and the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      data_r     <= '0;
      parity_r   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // The silence timer restarts on every device edge and saturates.
      if (fall) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          to_cnt  <= '0;
          inh_cnt <= '0;
          bit_cnt <= '0;
          if (start) begin
            data_r     <= data_in;
            parity_r   <= odd_parity(data_in);
            ps2_clk_oe <= 1'b1;
            busy       <= 1'b1;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          // Pull data low during the final inhibit cycle. This is the start bit.
          if (inh_cnt == INH_PRE) begin
            ps2_dat_oe <= 1'b1;
          end
          if (inh_cnt == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            to_cnt     <= '0;
            state      <= REQ;
          end
        end

        REQ: begin
          if (fall) begin
            ps2_dat_oe <= ~data_r[0];
            bit_cnt    <= 4'd1;
            state      <= SEND;
          end else if (timed_out) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end
        end

        SEND: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              ps2_dat_oe <= ~data_r[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              ps2_dat_oe <= ~parity_r;
            end else begin
              // Release data for the stop bit and wait for the acknowledge.
              ps2_dat_oe <= 1'b0;
              state      <= ACK;
            end
          end else if (timed_out) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end
        end

        ACK: begin
          if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
            if (!dat_sync_p1) begin
              state <= WAIT_IDLE;
            end else begin
              busy  <= 1'b0;
              err   <= 1'b1;
              state <= IDLE;
            end
`else
            state <= WAIT_IDLE;
`endif
          end else if (timed_out) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end
        end

        WAIT_IDLE: begin
          if (line_idle) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (timed_out) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx. A behavioural PS/2 device shares the
// open-drain lines with the host. It clocks the frame, captures each bit at
// the rising clock edge, and optionally acknowledges.
module tb_ps2_host_tx;

  localparam int INH = 2500;
  localparam int TO  = 1000;
  localparam int H   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start and measure the inhibit phase up to the request-to-send.
  task automatic start_and_inhibit(input logic [7:0] d, input string tag);
    int inh_n;
    int dat_n;
    logic last_dat;
    inh_n = 0;
    dat_n = 0;
    last_dat = 1'b0;
    @(negedge clk);
    data_in = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_in = ~d;
    check({tag, ".busy_on"}, {31'd0, busy}, 32'd1);
    while (ps2_clk_oe === 1'b1 && inh_n < INH + 100) begin
      inh_n++;
      if (ps2_dat_oe) dat_n++;
      last_dat = ps2_dat_oe;
      @(negedge clk);
    end
    check({tag, ".inhibit_len"}, inh_n, INH);
    check({tag, ".start_bit_cycles"}, dat_n, 32'd1);
    check({tag, ".start_bit_last"}, {31'd0, last_dat}, 32'd1);
    check({tag, ".req_dat_oe"}, {31'd0, ps2_dat_oe}, 32'd1);
  endtask

  // Device clocks 11 edges. rst_edge != 0 asserts reset after that falling edge.
  task automatic device_frame(input logic [7:0] d, input bit ack, input int rst_edge,
                              input bit restart, input string tag);
    logic [10:1] bits;
    bits = '0;
    for (int e = 1; e <= 11; e++) begin
      repeat (H / 2) @(negedge clk);
      if (e == 11) dev_dat_low = ack;
      repeat (H - H / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      if (e == rst_edge) begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, ".rst_clk_oe"}, {31'd0, ps2_clk_oe}, 32'd0);
        check({tag, ".rst_dat_oe"}, {31'd0, ps2_dat_oe}, 32'd0);
        check({tag, ".rst_busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".rst_pulses"}, {30'd0, done, err}, 32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, ".rst_hold_pulses"}, {30'd0, done, err}, 32'd0);
        rst = 1'b1;
        return;
      end
      if (restart && e == 4) begin
        repeat (2) @(negedge clk);
        start = 1'b1;
        data_in = 8'h55;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy_during_send"}, {31'd0, busy}, 32'd1);
        repeat (H - 3) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      bits[e] = ps2_dat_in;
      dev_clk_low = 1'b0;
    end
    dev_dat_low = 1'b0;
    check({tag, ".data_bits"}, {24'd0, bits[8:1]}, {24'd0, d});
    check({tag, ".parity"}, {31'd0, bits[9]}, {31'd0, ~^d});
    check({tag, ".stop"}, {31'd0, bits[10]}, 32'd1);
  endtask

  // Wait for the completion pulse and check its kind and its single-cycle width.
  task automatic finish_check(input bit exp_done, input string tag);
    int n;
    n = 0;
    while (!(done | err) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
    check({tag, ".err"}, {31'd0, err}, {31'd0, ~exp_done});
    @(negedge clk);
    check({tag, ".after_pulse"}, {29'd0, busy, done, err}, 32'd0);
    check({tag, ".after_oe"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
  endtask

  initial begin
    bit ack_exp_done;
    bit bad;
    int n;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_exp_done = 1'b0;
`else
    ack_exp_done = 1'b1;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.outputs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy, done, err}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset.outputs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy, done, err}, 32'd0);

    // Device-originated clock edges while idle are ignored
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (10) begin @(negedge clk); bad |= (busy | done | err | ps2_clk_oe | ps2_dat_oe); end
      dev_clk_low = 1'b0;
      repeat (10) begin @(negedge clk); bad |= (busy | done | err | ps2_clk_oe | ps2_dat_oe); end
    end
    check("idle_traffic.ignored", {31'd0, bad}, 32'd0);

    // LED command 0xED with acknowledge
    start_and_inhibit(8'hED, "ed");
    device_frame(8'hED, 1'b1, 0, 1'b0, "ed");
    finish_check(1'b1, "ed");

    // Parity boundaries
    repeat (5) @(negedge clk);
    start_and_inhibit(8'h00, "x00");
    device_frame(8'h00, 1'b1, 0, 1'b0, "x00");
    finish_check(1'b1, "x00");
    repeat (5) @(negedge clk);
    start_and_inhibit(8'h01, "x01");
    device_frame(8'h01, 1'b1, 0, 1'b0, "x01");
    finish_check(1'b1, "x01");

    // Missing acknowledge
    repeat (5) @(negedge clk);
    start_and_inhibit(8'h3C, "noack");
    device_frame(8'h3C, 1'b0, 0, 1'b0, "noack");
    finish_check(ack_exp_done, "noack");

    // Second start during SEND is ignored
    repeat (5) @(negedge clk);
    start_and_inhibit(8'hA7, "restart");
    device_frame(8'hA7, 1'b1, 0, 1'b1, "restart");
    finish_check(1'b1, "restart");
    repeat (20) @(negedge clk);
    check("restart.stays_idle", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);

    // Reset at edge 5, then a fresh transfer completes
    repeat (5) @(negedge clk);
    start_and_inhibit(8'h96, "rstmid");
    device_frame(8'h96, 1'b1, 5, 1'b0, "rstmid");
    repeat (5) @(negedge clk);
    start_and_inhibit(8'hFF, "after_rst");
    device_frame(8'hFF, 1'b1, 0, 1'b0, "after_rst");
    finish_check(1'b1, "after_rst");

    // Device never clocks: timeout measured from REQ entry
    repeat (5) @(negedge clk);
    start_and_inhibit(8'hA5, "timeout");
    n = 0;
    while (!err && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout.latency", n, TO);
    check("timeout.oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("timeout.done_busy", {30'd0, done, busy}, 32'd0);
    @(negedge clk);
    check("timeout.err_pulse", {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
